dfp_normalize_pipe: RTL and testbench
=====================================

Name: dfp_normalize_pipe

Overview:
- Parametrised decimal floating-point normalizer for the DFP arithmetic units (add/mul/div back ends), sitting between the raw-result datapath and the rounder.
- Reduces a double-width BCD significand to N+1 digits plus sticky, fully normalizes with a complete leading-zero-digit count (denormals supported), and denormalizes underflowed results.
- Unlike the fixed 128-bit normalizer, width is generic and a valid/ready pipeline with backpressure and a tag field replaces the free-running ce.

Parameters:
- N, 34, fraction digits; input significand 2N+2 digits, output significand N+1 digits.
- EW, 14, exponent width (two's complement when in_under=1).
- EMAX, 14'h2FFF, exponent value reserved for NaN/infinity.
- TAGW, 4, width of the opaque tag carried alongside each operand.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage 1 can accept
- in_sign  in  1  sign
- in_exp  in  EW  exponent
- in_sig  in  (2N+2)*4  BCD significand, digit 2N+1 most significant
- in_nan, in_qnan, in_snan, in_inf  in  1 each  special flags
- in_under  in  1  exponent has underflowed (negative)
- in_tag  in  TAGW  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_sign, out_nan, out_qnan, out_snan, out_inf  out  1 each  delayed flags
- out_exp  out  EW  normalized exponent
- out_sig  out  (N+1)*4  normalized significand, one whole digit
- out_sticky  out  1  OR of all discarded nonzero bits
- out_inexact  out  1  equals out_sticky
- out_under  out  1  result was denormalized
- out_tag  out  TAGW  delayed tag

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits cleared; out_valid=0, all data outputs 0. Reset mid-operation discards every in-flight operand. in_ready=1 in the first cycle after reset.
- Pipeline: 4 registered stages, each with a valid bit. Stage k loads when it is empty or stage k+1 loads/consumes this cycle. in_ready = stage-1 loadable. With out_ready held high, latency is exactly 4 cycles and throughput is 1/cycle. Stalls hold all stage data; order is preserved and no operand is lost or duplicated.
- S1, reduce: special = in_nan|in_inf|(in_exp==EMAX).
  - If digit 2N+1 != 0 and in_exp != EMAX and !in_under: sig = digits[2N+1:N+1], exp+1, sticky = |digits[N:0].
  - Otherwise: sig = digits[2N:N], exp unchanged, sticky = |digits[N-1:0].
- S2, count: lz = count of leading zero digits of the N+1-digit sig (0..N+1); zero = (lz==N+1).
- S3, shift:
  - special or zero: no shift, exp unchanged (zero result keeps its exponent, sig=0, sticky kept).
  - in_under: right shift by r = min(-exp, N+2) digits; exp=0; sticky |= OR of shifted-out digits; under flag=1.
  - Otherwise: left shift by l = min(lz, exp) digits with zeros shifted in; exp -= l; the exponent never goes below 0.
- S4: register outputs; out_inexact = out_sticky.
- Arithmetic: exponent increment/decrement is EW-bit; shift amounts are computed in digits and multiplied by 4.

Test Plan (N=4, EW=8, EMAX=8'h7F, in_sig 10 digits):
- in_sig=0x0012345678, exp=10 -> out_sig=0x12340, exp=9, sticky=1, valid exactly 4 cycles after accept.
- in_sig=0x1234567890, exp=5 -> out_sig=0x12345, exp=6, sticky=1; same with exp=EMAX -> out_sig=0x23456, exp=0x7F, no shift.
- in_under=1, exp=8'hFE, in_sig=0x0123450000 -> out_sig=0x00123, exp=0, sticky=1, out_under=1.
- in_sig=0x0000120000, exp=1 -> lz=3 clamped to 1: out_sig=0x00120, exp=0; in_sig=0, exp=20 -> out_sig=0, exp=20, sticky=0.
- 6 back-to-back operands with out_ready low for cycles 3-6 -> in_ready drops when all 4 stages are full; all 6 results emerge in order with matching tags.
- rst_n low for 1 cycle with 3 operands in flight -> out_valid=0 next cycle, none of those 3 ever emerge.

Source files
------------

// File: rtl/dfp_normalize_pipe.sv
// Decimal floating-point normalizer: reduces a 2N+2 digit BCD significand to N+1 digits
// plus sticky, normalizes by leading-zero-digit count and denormalizes underflowed results.
module dfp_normalize_pipe #(
  parameter int            N    = 34,
  parameter int            EW   = 14,
  parameter logic [EW-1:0] EMAX = 14'h2FFF,
  parameter int            TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EW-1:0]        in_exp,
  input  logic [(2*N+2)*4-1:0] in_sig,
  input  logic                 in_nan,
  input  logic                 in_qnan,
  input  logic                 in_snan,
  input  logic                 in_inf,
  input  logic                 in_under,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_nan,
  output logic                 out_qnan,
  output logic                 out_snan,
  output logic                 out_inf,
  output logic [EW-1:0]        out_exp,
  output logic [(N+1)*4-1:0]   out_sig,
  output logic                 out_sticky,
  output logic                 out_inexact,
  output logic                 out_under,
  output logic [TAGW-1:0]      out_tag
);

  localparam int IW  = (2*N+2)*4;
  localparam int OW  = (N+1)*4;
  localparam int LZW = $clog2(N+2);
  localparam int SW  = $clog2(N+3);

  function automatic logic [LZW-1:0] lead_zero_digits(input logic [OW-1:0] s);
    logic [LZW-1:0] cnt;
    logic           found;
    cnt   = '0;
    found = 1'b0;
    for (int i = N; i >= 0; i--) begin
      if (!found) begin
        if (s[i*4 +: 4] != 4'd0) found = 1'b1;
        else                     cnt   = cnt + LZW'(1);
      end
    end
    return cnt;
  endfunction

  // Underflowed exponents are negative; a shift of N+2 digits already clears the whole significand.
  function automatic logic [SW-1:0] sat_under_shift(input logic [EW-1:0] e);
    logic signed [EW:0] mag;
    mag = -$signed({e[EW-1], e});
    if (mag[EW] || (mag == '0))           return '0;
    if (mag >= $signed((EW+1)'(N+2)))     return SW'(N+2);
    return mag[SW-1:0];
  endfunction

  function automatic logic [LZW-1:0] sat_left_shift(input logic [LZW-1:0] lz, input logic [EW-1:0] e);
    if (e < EW'(lz)) return e[LZW-1:0];
    return lz;
  endfunction

  logic vld_p1, vld_p2, vld_p3, vld_p4;
  logic adv_p1, adv_p2, adv_p3, adv_p4;

  assign adv_p4    = !vld_p4 || out_ready;
  assign adv_p3    = !vld_p3 || adv_p4;
  assign adv_p2    = !vld_p2 || adv_p3;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
      if (adv_p3) vld_p3 <= vld_p2;
      if (adv_p4) vld_p4 <= vld_p3;
    end
  end

  // ---- stage 1: reduce to N+1 digits ----
  logic            carry_c1;
  logic [OW-1:0]   sig_c1;
  logic [EW-1:0]   exp_c1;
  logic            sticky_c1;

  always_comb begin
    carry_c1 = (in_sig[IW-1 -: 4] != 4'd0) && (in_exp != EMAX) && !in_under;
    if (carry_c1) begin
      sig_c1    = in_sig[IW-1 -: OW];
      exp_c1    = in_exp + EW'(1);
      sticky_c1 = |in_sig[OW-1:0];
    end else begin
      sig_c1    = in_sig[IW-5 -: OW];
      exp_c1    = in_exp;
      sticky_c1 = |in_sig[N*4-1:0];
    end
  end

  logic            sign_p1, nan_p1, qnan_p1, snan_p1, inf_p1, under_p1, special_p1, sticky_p1;
  logic [EW-1:0]   exp_p1;
  logic [OW-1:0]   sig_p1;
  logic [TAGW-1:0] tag_p1;

  always_ff @(posedge clk) begin
    if (adv_p1) begin
      sign_p1    <= in_sign;
      nan_p1     <= in_nan;
      qnan_p1    <= in_qnan;
      snan_p1    <= in_snan;
      inf_p1     <= in_inf;
      under_p1   <= in_under;
      special_p1 <= in_nan || in_inf || (in_exp == EMAX);
      sticky_p1  <= sticky_c1;
      exp_p1     <= exp_c1;
      sig_p1     <= sig_c1;
      tag_p1     <= in_tag;
    end
  end

  // ---- stage 2: leading-zero-digit count ----
  logic [LZW-1:0] lz_c2;
  assign lz_c2 = lead_zero_digits(sig_p1);

  logic            sign_p2, nan_p2, qnan_p2, snan_p2, inf_p2, under_p2, special_p2, sticky_p2, zero_p2;
  logic [EW-1:0]   exp_p2;
  logic [OW-1:0]   sig_p2;
  logic [LZW-1:0]  lz_p2;
  logic [TAGW-1:0] tag_p2;

  always_ff @(posedge clk) begin
    if (adv_p2) begin
      sign_p2    <= sign_p1;
      nan_p2     <= nan_p1;
      qnan_p2    <= qnan_p1;
      snan_p2    <= snan_p1;
      inf_p2     <= inf_p1;
      under_p2   <= under_p1;
      special_p2 <= special_p1;
      sticky_p2  <= sticky_p1;
      zero_p2    <= (lz_c2 == LZW'(N+1));
      lz_p2      <= lz_c2;
      exp_p2     <= exp_p1;
      sig_p2     <= sig_p1;
      tag_p2     <= tag_p1;
    end
  end

  // ---- stage 3: normalize or denormalize ----
  logic [SW-1:0]  rsh_c3;
  logic [LZW-1:0] lsh_c3;
  logic [OW-1:0]  lost_c3;
  logic [OW-1:0]  sig_c3;
  logic [EW-1:0]  exp_c3;
  logic           sticky_c3;
  logic           denorm_c3;

  always_comb begin
    rsh_c3    = sat_under_shift(exp_p2);
    lsh_c3    = sat_left_shift(lz_p2, exp_p2);
    lost_c3   = '0;
    sig_c3    = sig_p2;
    exp_c3    = exp_p2;
    sticky_c3 = sticky_p2;
    denorm_c3 = 1'b0;
    if (!(special_p2 || zero_p2)) begin
      if (under_p2) begin
        lost_c3   = sig_p2 & ~({OW{1'b1}} << {rsh_c3, 2'b00});
        sig_c3    = sig_p2 >> {rsh_c3, 2'b00};
        exp_c3    = '0;
        sticky_c3 = sticky_p2 || (|lost_c3);
        denorm_c3 = 1'b1;
      end else begin
        sig_c3    = sig_p2 << {lsh_c3, 2'b00};
        exp_c3    = exp_p2 - EW'(lsh_c3);
      end
    end
  end

  logic            sign_p3, nan_p3, qnan_p3, snan_p3, inf_p3, under_p3, sticky_p3;
  logic [EW-1:0]   exp_p3;
  logic [OW-1:0]   sig_p3;
  logic [TAGW-1:0] tag_p3;

  always_ff @(posedge clk) begin
    if (adv_p3) begin
      sign_p3   <= sign_p2;
      nan_p3    <= nan_p2;
      qnan_p3   <= qnan_p2;
      snan_p3   <= snan_p2;
      inf_p3    <= inf_p2;
      under_p3  <= denorm_c3;
      sticky_p3 <= sticky_c3;
      exp_p3    <= exp_c3;
      sig_p3    <= sig_c3;
      tag_p3    <= tag_p2;
    end
  end

  // ---- stage 4: output register, cleared on reset ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sign   <= 1'b0;
      out_nan    <= 1'b0;
      out_qnan   <= 1'b0;
      out_snan   <= 1'b0;
      out_inf    <= 1'b0;
      out_under  <= 1'b0;
      out_sticky <= 1'b0;
      out_exp    <= '0;
      out_sig    <= '0;
      out_tag    <= '0;
    end else if (adv_p4) begin
      out_sign   <= sign_p3;
      out_nan    <= nan_p3;
      out_qnan   <= qnan_p3;
      out_snan   <= snan_p3;
      out_inf    <= inf_p3;
      out_under  <= under_p3;
      out_sticky <= sticky_p3;
      out_exp    <= exp_p3;
      out_sig    <= sig_p3;
      out_tag    <= tag_p3;
    end
  end

  assign out_inexact = out_sticky;

endmodule

// File: tb/tb_dfp_normalize_pipe.sv
// Bench for dfp_normalize_pipe (N=4): directed vectors, random streams with backpressure,
// and mid-flight reset, checked against a decimal-integer reference model.
module tb_dfp_normalize_pipe;

  localparam int            N    = 4;
  localparam int            EW   = 8;
  localparam int            TAGW = 4;
  localparam logic [EW-1:0] EMAX = 8'h7F;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sign, in_nan, in_qnan, in_snan, in_inf, in_under;
  logic [7:0]  in_exp;
  logic [39:0] in_sig;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_sign, out_nan, out_qnan, out_snan, out_inf;
  logic [7:0]  out_exp;
  logic [19:0] out_sig;
  logic        out_sticky, out_inexact, out_under;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  dfp_normalize_pipe #(.N(N), .EW(EW), .EMAX(EMAX), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_nan(in_nan),
    .in_qnan(in_qnan), .in_snan(in_snan), .in_inf(in_inf), .in_under(in_under),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_nan(out_nan), .out_qnan(out_qnan), .out_snan(out_snan),
    .out_inf(out_inf), .out_exp(out_exp), .out_sig(out_sig), .out_sticky(out_sticky),
    .out_inexact(out_inexact), .out_under(out_under), .out_tag(out_tag)
  );

  typedef struct packed {
    logic       sign, nan, qnan, snan, inf;
    logic [7:0]  exp;
    logic [19:0] sig;
    logic       sticky, inexact, under;
    logic [3:0]  tag;
  } res_t;

  res_t q[$];
  int   aq[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   accepted, lat_chk, use_dir, rand_rdy, rdy_seen, seen_out;
  res_t dir_res;

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [39:0] b);
    longint v = 0;
    for (int i = 9; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [19:0] int2bcd(input longint v);
    logic [19:0] b = '0;
    longint      t = v;
    for (int i = 0; i < 5; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Works on the significand as a decimal number: divide to drop digits, multiply to shift left.
  function automatic res_t model(input logic sg, nn, qn, sn, inf, input logic [7:0] ex,
                                 input logic [39:0] sig, input logic und, input logic [3:0] tg);
    res_t   r;
    longint v, s;
    int     e, lz, sh;
    bit     st, spec;
    v    = bcd2int(sig);
    spec = nn || inf || (ex == EMAX);
    if ((v / p10(9)) != 0 && ex != EMAX && !und) begin
      s = v / p10(5); st = (v % p10(5)) != 0; e = (int'(ex) + 1) % 256;
    end else begin
      s = (v % p10(9)) / p10(4); st = (v % p10(4)) != 0; e = int'(ex);
    end
    lz = 5;
    while (lz > 0 && s >= p10(5 - lz)) lz--;
    r.under = 1'b0;
    if (!(spec || s == 0)) begin
      if (und) begin
        sh = -int'($signed(ex));
        if (sh < 0) sh = 0;
        if (sh > 6) sh = 6;
        st = st || ((s % p10(sh)) != 0);
        s  = s / p10(sh);
        e  = 0;
        r.under = 1'b1;
      end else begin
        sh = (lz < e) ? lz : e;
        s  = s * p10(sh);
        e  = e - sh;
      end
    end
    r.sign = sg; r.nan = nn; r.qnan = qn; r.snan = sn; r.inf = inf;
    r.exp = 8'(e); r.sig = int2bcd(s); r.sticky = st; r.inexact = st; r.tag = tg;
    return r;
  endfunction

  function automatic res_t mk(input logic [4:0] fl, input logic [7:0] ex, input logic [19:0] sg,
                              input logic st, input logic un, input logic [3:0] tg);
    return {fl, ex, sg, st, st, un, tg};
  endfunction

  function automatic res_t dut_res();
    return {out_sign, out_nan, out_qnan, out_snan, out_inf, out_exp, out_sig,
            out_sticky, out_inexact, out_under, out_tag};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step();
    res_t er;
    int   a;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    #1;
    rdy_seen = in_ready;
    accepted = 1'b0;
    if (rst_n) begin
      checks++;
      assert (in_ready === ((q.size() < 4) || out_ready)) else begin
        errors++;
        $error("FAIL in_ready got %b expected %b", in_ready, ((q.size() < 4) || out_ready));
      end
      if (out_valid && out_ready) begin
        seen_out = 1'b1;
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_out got tag %h expected no result", out_tag);
        end
        if (q.size() > 0) begin
          er = q.pop_front();
          a  = aq.pop_front();
          checks++;
          assert (dut_res() === er) else begin
            errors++;
            $error("FAIL result got %h expected %h", dut_res(), er);
          end
          if (lat_chk) begin
            checks++;
            assert ((cyc - a) === 4) else begin
              errors++;
              $error("FAIL latency got %0d expected 4", cyc - a);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(use_dir ? dir_res : model(in_sign, in_nan, in_qnan, in_snan, in_inf,
                                              in_exp, in_sig, in_under, in_tag));
        aq.push_back(cyc);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      aq.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue();
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 64 && !accepted; k++) step();
    checks++;
    assert (accepted === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout got %b expected 1", accepted);
    end
    in_valid = 1'b0;
    use_dir  = 1'b0;
  endtask

  task automatic send(input logic [39:0] sig, input logic [7:0] ex, input logic und,
                      input logic [4:0] fl, input logic [3:0] tg, input res_t dres);
    in_sig = sig; in_exp = ex; in_under = und; in_tag = tg;
    {in_sign, in_nan, in_qnan, in_snan, in_inf} = fl;
    use_dir = 1'b1;
    dir_res = dres;
    issue();
  endtask

  task automatic rand_inputs(input logic [3:0] tg);
    logic [39:0] s;
    int          nz;
    for (int i = 0; i < 10; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
    nz = $urandom_range(0, 10);
    for (int i = 0; i < nz; i++) s[(9-i)*4 +: 4] = 4'd0;
    in_sig   = s;
    in_under = 1'b0;
    case ($urandom_range(0, 5))
      0:       in_exp = 8'($urandom_range(0, 8));
      1:       in_exp = 8'($urandom);
      2, 3:    begin in_under = 1'b1; in_exp = 8'(256 - $urandom_range(1, 9)); end
      4:       in_exp = EMAX;
      default: begin in_under = 1'b1; in_exp = 8'($urandom_range(128, 255)); end
    endcase
    in_sign = 1'($urandom_range(0, 1));
    in_nan  = ($urandom_range(0, 9) == 0);
    in_inf  = ($urandom_range(0, 9) == 0);
    in_qnan = 1'($urandom_range(0, 1));
    in_snan = 1'($urandom_range(0, 1));
    in_tag  = tg;
    use_dir = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) step();
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  sent;
    bit  saw_stall;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sig = '0; in_exp = '0;
    in_under = 1'b0; in_tag = '0; {in_sign, in_nan, in_qnan, in_snan, in_inf} = 5'b0;
    lat_chk = 1'b1; use_dir = 1'b0; rand_rdy = 1'b0; seen_out = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(dut_res()), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Directed vectors, back to back, consumer always ready.
    send(40'h0012345678, 8'd10,  1'b0, 5'b00000, 4'h1, mk(5'b00000, 8'd9,   20'h12340, 1'b1, 1'b0, 4'h1));
    send(40'h1234567890, 8'd5,   1'b0, 5'b00000, 4'h2, mk(5'b00000, 8'd6,   20'h12345, 1'b1, 1'b0, 4'h2));
    send(40'h1234567890, 8'h7F,  1'b0, 5'b00000, 4'h3, mk(5'b00000, 8'h7F,  20'h23456, 1'b1, 1'b0, 4'h3));
    send(40'h0123450000, 8'hFE,  1'b1, 5'b00000, 4'h4, mk(5'b00000, 8'h00,  20'h00123, 1'b1, 1'b1, 4'h4));
    send(40'h0000120000, 8'd1,   1'b0, 5'b00000, 4'h5, mk(5'b00000, 8'h00,  20'h00120, 1'b0, 1'b0, 4'h5));
    send(40'h0000000000, 8'd20,  1'b0, 5'b00000, 4'h6, mk(5'b00000, 8'd20,  20'h00000, 1'b0, 1'b0, 4'h6));
    send(40'h0012345678, 8'd10,  1'b0, 5'b11100, 4'h7, mk(5'b11100, 8'd10,  20'h01234, 1'b1, 1'b0, 4'h7));
    send(40'h0999990000, 8'h80,  1'b1, 5'b00000, 4'h8, mk(5'b00000, 8'h00,  20'h00000, 1'b1, 1'b1, 4'h8));
    send(40'h9000000000, 8'hFF,  1'b0, 5'b10000, 4'h9, mk(5'b10000, 8'h00,  20'h90000, 1'b0, 1'b0, 4'h9));
    send(40'h0000000010, 8'd50,  1'b0, 5'b00000, 4'hA, mk(5'b00000, 8'd50,  20'h00000, 1'b1, 1'b0, 4'hA));
    drain();

    // Six back-to-back operands, consumer stalls for four cycles.
    lat_chk = 1'b0; sent = 0; saw_stall = 1'b0;
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 2 && t <= 5);
      if (sent < 6) begin
        rand_inputs(4'(sent));
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      step();
      if (accepted) sent++;
      if (!rdy_seen) saw_stall = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_stall_seen", 64'(saw_stall), 64'd1);
    drain();

    // Random stream, consumer always ready: full throughput, fixed latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(4'(i));
      issue();
    end
    drain();

    // Random stream with random backpressure and input gaps.
    lat_chk = 1'b0; rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      rand_inputs(4'(i));
      issue();
    end
    rand_rdy = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with three operands in flight: none of them may ever emerge.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(4'(i + 12));
      issue();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(dut_res()), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    seen_out = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("mid_rst_no_output", 64'(seen_out), 64'd0);

    send(40'h0012345678, 8'd10, 1'b0, 5'b00000, 4'h3, mk(5'b00000, 8'd9, 20'h12340, 1'b1, 1'b0, 4'h3));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
